// File: rtl/hazard_controller.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Load-use stalling and the stall counter exist only when HZ_LOAD_STALL_EN is defined.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             ex_forward_a,
    output logic             ex_forward_b,
    output logic             mem_forward_a,
    output logic             mem_forward_b,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    logic       dec_rd_rs, dec_rd_rt, dec_wr;
    logic [4:0] dec_dst;
    logic       slot1_wr_d, slot1_wr_q, slot2_wr_d, slot2_wr_q;
    logic [4:0] slot1_dst_d, slot1_dst_q, slot2_dst_d, slot2_dst_q;
    logic       active, hazard;
    logic       ex_a_raw, ex_b_raw, mem_a_raw, mem_b_raw;
`ifdef HZ_LOAD_STALL_EN
    logic             dec_load;
    logic             slot1_load_d, slot1_load_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;
`endif

    always_comb begin
        dec_rd_rs = 1'b0;
        dec_rd_rt = 1'b0;
        dec_wr    = 1'b0;
        dec_dst   = 5'd0;
`ifdef HZ_LOAD_STALL_EN
        dec_load  = 1'b0;
`endif
        case (opcode)
            6'h00: begin
                dec_rd_rs = 1'b1;
                if (funct != 6'h08) begin
                    dec_rd_rt = 1'b1;
                    dec_wr    = 1'b1;
                    dec_dst   = rd;
                end
            end
            6'h23: begin
                dec_rd_rs = 1'b1;
                dec_wr    = 1'b1;
                dec_dst   = rt;
`ifdef HZ_LOAD_STALL_EN
                dec_load  = 1'b1;
`endif
            end
            6'h2B, 6'h04: begin
                dec_rd_rs = 1'b1;
                dec_rd_rt = 1'b1;
            end
            6'h08: begin
                dec_rd_rs = 1'b1;
                dec_wr    = 1'b1;
                dec_dst   = rt;
            end
            default: ;
        endcase
        // $0 is never a real producer, so it must not trigger forwarding
        if (dec_dst == 5'd0) begin
            dec_wr = 1'b0;
        end
    end

    assign active    = instr_valid && !rst;
    assign ex_a_raw  = active && dec_rd_rs && slot1_wr_q && (slot1_dst_q == rs);
    assign ex_b_raw  = active && dec_rd_rt && slot1_wr_q && (slot1_dst_q == rt);
    assign mem_a_raw = active && dec_rd_rs && slot2_wr_q && (slot2_dst_q == rs) && !ex_a_raw;
    assign mem_b_raw = active && dec_rd_rt && slot2_wr_q && (slot2_dst_q == rt) && !ex_b_raw;

`ifdef HZ_LOAD_STALL_EN
    assign hazard      = active && slot1_load_q && (ex_a_raw || ex_b_raw);
    assign stall_count = stall_count_q;
`else
    assign hazard      = 1'b0;
    assign stall_count = '0;
`endif

    assign ex_forward_a  = ex_a_raw && !hazard;
    assign ex_forward_b  = ex_b_raw && !hazard;
    assign mem_forward_a = mem_a_raw && !hazard;
    assign mem_forward_b = mem_b_raw && !hazard;
    assign stall         = hazard;
    assign bubble        = hazard;

    // A stalled instruction is re-presented, so slot1 takes a bubble instead of it
    always_comb begin
        slot2_wr_d  = slot1_wr_q;
        slot2_dst_d = slot1_dst_q;
        slot1_wr_d  = 1'b0;
        slot1_dst_d = 5'd0;
`ifdef HZ_LOAD_STALL_EN
        slot1_load_d  = 1'b0;
        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`endif
        if (instr_valid && !hazard) begin
            slot1_wr_d  = dec_wr;
            slot1_dst_d = dec_dst;
`ifdef HZ_LOAD_STALL_EN
            slot1_load_d = dec_load && dec_wr;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot1_wr_q    <= 1'b0;
            slot1_dst_q   <= 5'd0;
            slot2_wr_q    <= 1'b0;
            slot2_dst_q   <= 5'd0;
`ifdef HZ_LOAD_STALL_EN
            slot1_load_q  <= 1'b0;
            stall_count_q <= '0;
`endif
        end else begin
            slot1_wr_q    <= slot1_wr_d;
            slot1_dst_q   <= slot1_dst_d;
            slot2_wr_q    <= slot2_wr_d;
            slot2_dst_q   <= slot2_dst_d;
`ifdef HZ_LOAD_STALL_EN
            slot1_load_q  <= slot1_load_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed pipeline scenarios plus random
// instruction streams against a producer-history model; honours HZ_LOAD_STALL_EN.
module tb_hazard_controller;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
    logic             stall, bubble;
    logic [CNT_W-1:0] stall_count;

    int nCompared = 0;
    int nMismatched = 0;

    // Model: destination register of the producer one ahead (hist1) and two ahead (hist2),
    // -1 meaning nothing that can be forwarded
    int hist1Dst = -1;
    int hist2Dst = -1;
    bit hist1Load = 1'b0;
    int modelCount = 0;

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .ex_forward_a (ex_forward_a),
        .ex_forward_b (ex_forward_b),
        .mem_forward_a(mem_forward_a),
        .mem_forward_b(mem_forward_b),
        .stall        (stall),
        .bubble       (bubble),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input int rsI, input int rtI, input int rdI, input logic [5:0] fn);
        logic [4:0] a, b, c;
        a = 5'(rsI);
        b = 5'(rtI);
        c = 5'(rdI);
        return {6'h00, a, b, c, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input int rsI, input int rtI, input logic [15:0] imm);
        logic [4:0] a, b;
        a = 5'(rsI);
        b = 5'(rtI);
        return {op, a, b, imm};
    endfunction

    // Read set and destination of an instruction straight from the ISA table
    function automatic void decodeModel(input logic [31:0] ins, output bit readsRs, output bit readsRt,
                                        output int dst, output bit isLoad);
        int op, rsI, rtI, rdI, fn;
        op = int'(ins[31:26]); rsI = int'(ins[25:21]); rtI = int'(ins[20:16]);
        rdI = int'(ins[15:11]); fn = int'(ins[5:0]);
        readsRs = 0; readsRt = 0; dst = -1; isLoad = 0;
        if (op == 0 && fn == 8) readsRs = 1;
        else if (op == 0) begin readsRs = 1; readsRt = 1; dst = rdI; end
        else if (op == 'h23) begin readsRs = 1; dst = rtI; isLoad = 1; end
        else if (op == 'h2B || op == 'h04) begin readsRs = 1; readsRt = 1; end
        else if (op == 'h08) begin readsRs = 1; dst = rtI; end
        if (dst == 0) begin dst = -1; isLoad = 0; end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic v, input logic r);
        bit rdRs, rdRt, ld, expStall;
        int dst, rsI, rtI;
        bit eA, eB, mA, mB;
        logic [5:0] expVec, gotVec;
        @(negedge clk);
        instr = ins;
        instr_valid = v;
        rst = r;
        #1;
        decodeModel(ins, rdRs, rdRt, dst, ld);
        rsI = int'(ins[25:21]);
        rtI = int'(ins[20:16]);
        eA = 0; eB = 0; mA = 0; mB = 0; expStall = 0;
        if (v && !r) begin
            eA = rdRs && (hist1Dst == rsI);
            eB = rdRt && (hist1Dst == rtI);
            mA = rdRs && (hist2Dst == rsI) && !eA;
            mB = rdRt && (hist2Dst == rtI) && !eB;
`ifdef HZ_LOAD_STALL_EN
            expStall = hist1Load && (eA || eB);
`endif
            if (expStall) begin eA = 0; eB = 0; mA = 0; mB = 0; end
        end
        expVec = {eA, eB, mA, mB, expStall, expStall};
        gotVec = {ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b, stall, bubble};
        checkOutput({tag, "/fwd"}, 32'(gotVec), 32'(expVec));
        checkOutput({tag, "/cnt"}, 32'(stall_count), 32'(modelCount));
        @(posedge clk);
        if (r) begin
            hist1Dst = -1; hist2Dst = -1; hist1Load = 0; modelCount = 0;
        end else begin
            hist2Dst = hist1Dst;
            if (v && !expStall) begin hist1Dst = dst; hist1Load = ld; end
            else begin hist1Dst = -1; hist1Load = 0; end
            if (expStall && modelCount < CNT_MAX) modelCount++;
        end
    endtask

    initial begin
        logic [31:0] nop, addA, lwA, useA;
        nop = 32'h0;
        rst = 1'b1;
        instr = 32'h0;
        instr_valid = 1'b0;
        applyStimulus("reset0", nop, 1'b0, 1'b1);
        applyStimulus("reset1", rType(1, 2, 3, 6'h20), 1'b1, 1'b1);

        applyStimulus("raw1", rType(1, 2, 3, 6'h20), 1'b1, 1'b0);
        applyStimulus("raw1b", rType(3, 3, 4, 6'h20), 1'b1, 1'b0);

        applyStimulus("mem1", rType(1, 2, 3, 6'h20), 1'b1, 1'b0);
        applyStimulus("mem1n", nop, 1'b1, 1'b0);
        applyStimulus("mem1s", rType(3, 0, 5, 6'h22), 1'b1, 1'b0);

        applyStimulus("yng1", rType(1, 2, 3, 6'h20), 1'b1, 1'b0);
        applyStimulus("yng2", iType(6'h08, 1, 3, 16'h4), 1'b1, 1'b0);
        applyStimulus("yng3", rType(3, 3, 6, 6'h20), 1'b1, 1'b0);

        lwA = iType(6'h23, 1, 8, 16'h0);
        useA = rType(8, 2, 9, 6'h20);
        applyStimulus("lu1", lwA, 1'b1, 1'b0);
        applyStimulus("lu2", useA, 1'b1, 1'b0);
        applyStimulus("lu3", useA, 1'b1, 1'b0);
        applyStimulus("lu4", nop, 1'b1, 1'b0);

        addA = rType(1, 2, 0, 6'h20);
        applyStimulus("zero1", addA, 1'b1, 1'b0);
        applyStimulus("zero2", rType(0, 0, 7, 6'h20), 1'b1, 1'b0);
        applyStimulus("inv1", rType(1, 2, 3, 6'h20), 1'b1, 1'b0);
        applyStimulus("inv2", rType(3, 3, 4, 6'h20), 1'b0, 1'b0);

        applyStimulus("rs1", lwA, 1'b1, 1'b0);
        applyStimulus("rs2", useA, 1'b1, 1'b1);
        applyStimulus("rs3", useA, 1'b1, 1'b0);

        for (int k = 0; k < CNT_MAX + 4; k++) begin
            applyStimulus("sat_lw", lwA, 1'b1, 1'b0);
            applyStimulus("sat_use", useA, 1'b1, 1'b0);
            applyStimulus("sat_re", useA, 1'b1, 1'b0);
        end

        for (int k = 0; k < 600; k++) begin
            logic [31:0] ri;
            int sel, a, b, c;
            sel = int'($urandom_range(0, 7));
            a = int'($urandom_range(0, 3));
            b = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            case (sel)
                0: ri = rType(a, b, c, 6'h20);
                1: ri = rType(a, b, c, 6'h08);
                2: ri = iType(6'h23, a, b, 16'(k));
                3: ri = iType(6'h2B, a, b, 16'h8);
                4: ri = iType(6'h08, a, b, 16'h1);
                5: ri = iType(6'h04, a, b, 16'h2);
                6: ri = {6'h02, 26'(k)};
                default: ri = iType(6'h23, a, b, 16'h0);
            endcase
            applyStimulus("rand", ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
